// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the plot framebuffer.
//   - controller state encoding
//   - screen geometry, memory depth and address width
//   - xy_to_addr: row-major pixel address y*160 + x built from shifts
package fb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_DEPTH = 19200;
    localparam int ADDR_W   = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN_RD,
        SCAN_OUT,
        DONE
    } state_t;

    // y*160 = y*128 + y*32, so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = ADDR_W'(y);
        xw = ADDR_W'(x);
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port pixel memory.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates one cycle after re, holds otherwise
//   raddr  : read address
//   rdata  : registered read data (read-before-write on address collision)
// Contents are not reset, so the array maps onto block RAM.
module fb_ram
    import fb_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int AW     = ADDR_W,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Both accesses use non-blocking assignment, so a same-address read
    // in the write cycle observes the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/plot_framebuffer.sv
// plot_framebuffer: stores pixels from the plot interface and streams the
// frame back in raster order.
//   clk, rst_n          : clock, asynchronous active-low reset
//   vga_x/y/colour/plot : pixel plot input; out-of-range plots are dropped
//   clear_start         : start filling the frame with black (19200 cycles)
//   scan_start          : start a raster readback of the whole frame
//   scan_x/y/colour     : current output pixel, held while not accepted
//   scan_valid          : output pixel valid
//   scan_ready          : downstream accepts the pixel
//   frame_done          : one-cycle pulse after the last beat is accepted
//   busy                : controller is clearing or scanning
module plot_framebuffer
    import fb_pkg::*;
#(
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_W-1:0]      vga_x,
    input  logic [Y_W-1:0]      vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_start,
    input  logic                scan_start,
    output logic [X_W-1:0]      scan_x,
    output logic [Y_W-1:0]      scan_y,
    output logic [COLOUR_W-1:0] scan_colour,
    output logic                scan_valid,
    input  logic                scan_ready,
    output logic                frame_done,
    output logic                busy
);

    localparam logic [X_W-1:0]    X_LAST   = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(SCREEN_H - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [X_W-1:0]      x_cnt;
    logic [Y_W-1:0]      y_cnt;

    logic                accept;
    logic                plot_ok;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [COLOUR_W-1:0] ram_wdata;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [COLOUR_W-1:0] ram_rdata;

    assign accept = (state == SCAN_OUT) && scan_ready;

    // Plots are taken while idle or scanning; CLEAR owns the write port
    // and DONE is a single bookkeeping cycle.
    assign plot_ok = vga_plot && (vga_x <= X_LAST) && (vga_y <= Y_LAST) &&
                     ((state == IDLE) || (state == SCAN_RD) || (state == SCAN_OUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLEAR;
                end else if (scan_start) begin
                    state_next = SCAN_RD;
                end
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = IDLE;
                end
            end
            SCAN_RD: begin
                state_next = SCAN_OUT;
            end
            SCAN_OUT: begin
                if (scan_ready) begin
                    state_next = ((x_cnt == X_LAST) && (y_cnt == Y_LAST)) ? DONE : SCAN_RD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear address counter and raster position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + ADDR_W'(1);
            end else begin
                clr_cnt <= '0;
            end

            if (accept) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
                end else begin
                    x_cnt <= x_cnt + X_W'(1);
                end
            end else if (state == DONE) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
        end
    end

    // Write port: clear has priority over plotting.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = xy_to_addr(vga_x, vga_y);
        ram_wdata = vga_colour;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = '0;
        end else if (plot_ok) begin
            ram_we    = 1'b1;
        end
    end

    // The read is launched only in SCAN_RD, so rdata stays put for as long
    // as SCAN_OUT waits on scan_ready.
    assign ram_re    = (state == SCAN_RD);
    assign ram_raddr = xy_to_addr(x_cnt, y_cnt);

    fb_ram #(
        .DEPTH  (FB_DEPTH),
        .AW     (ADDR_W),
        .DATA_W (COLOUR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The RAM output register has no reset; gating by state gives a
    // defined zero colour whenever no beat is being presented.
    assign scan_x      = x_cnt;
    assign scan_y      = y_cnt;
    assign scan_colour = (state == SCAN_OUT) ? ram_rdata : '0;
    assign scan_valid  = (state == SCAN_OUT);
    assign frame_done  = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_plot_framebuffer.sv
module tb_plot_framebuffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       clear_start;
    logic       scan_start;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic [2:0] scan_colour;
    logic       scan_valid;
    logic       scan_ready;
    logic       frame_done;
    logic       busy;

    always #5 clk = ~clk;

    plot_framebuffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .clear_start (clear_start),
        .scan_start  (scan_start),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_colour (scan_colour),
        .scan_valid  (scan_valid),
        .scan_ready  (scan_ready),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0]  model [0:19199];
    logic [17:0] sb_q [$];

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       acc;
    } plot_vec_t;

    plot_vec_t vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        @(negedge clk);
        vga_x      = x;
        vga_y      = y;
        vga_colour = c;
        vga_plot   = 1'b1;
        @(negedge clk);
        vga_plot   = 1'b0;
    endtask

    task automatic load_expected();
        sb_q.delete();
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                sb_q.push_back({8'(x), 7'(y), model[y * 160 + x]});
            end
        end
    endtask

    task automatic run_scan(input bit do_stall, input bit do_reset);
        int         busy_cyc;
        int         done_cnt;
        int         stall_cnt;
        bit         stalled;
        bit         after_stall;
        bit         aborted;
        logic [2:0] held_c;
        logic [17:0] expv;
        logic [14:0] last_xy;
        busy_cyc    = 0;
        done_cnt    = 0;
        stall_cnt   = 0;
        stalled     = 0;
        after_stall = 0;
        aborted     = 0;
        held_c      = '0;
        last_xy     = '0;
        load_expected();
        @(negedge clk);
        scan_ready = 1'b1;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!busy) break;
            busy_cyc++;
            if (frame_done) done_cnt++;
            if (do_reset && scan_valid && scan_x == 8'd80 && scan_y == 7'd60) begin
                rst_n = 1'b0;
                #1;
                chk("rst_scan_valid", 32'(scan_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_scan_x", 32'(scan_x), 32'd0);
                chk("rst_scan_y", 32'(scan_y), 32'd0);
                chk("rst_frame_done", 32'(frame_done), 32'd0);
                aborted = 1;
                break;
            end
            if (do_stall && !stalled && scan_valid && scan_x == 8'd10 && scan_y == 7'd0) begin
                stalled    = 1;
                stall_cnt  = 5;
                held_c     = scan_colour;
                scan_ready = 1'b0;
            end else if (stall_cnt > 0) begin
                chk("stall_hold", 32'({scan_valid, scan_x, scan_y, scan_colour}),
                    32'({1'b1, 8'd10, 7'd0, held_c}));
                stall_cnt--;
                if (stall_cnt == 0) scan_ready = 1'b1;
            end
            if (scan_valid && scan_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_size", 32'(sb_q.size()), 32'd1);
                end else begin
                    expv = sb_q.pop_front();
                    chk("beat", 32'({scan_x, scan_y, scan_colour}), 32'(expv));
                    if (after_stall) begin
                        chk("after_stall", 32'({scan_x, scan_y}), 32'({8'd11, 7'd0}));
                        after_stall = 0;
                    end
                    if (stalled && scan_x == 8'd10 && scan_y == 7'd0) after_stall = 1;
                    last_xy = {scan_x, scan_y};
                end
            end
        end
        if (!aborted) begin
            chk("busy_cycles", 32'(busy_cyc), do_stall ? 32'd38406 : 32'd38401);
            chk("frame_done_cnt", 32'(done_cnt), 32'd1);
            chk("sb_left", 32'(sb_q.size()), 32'd0);
            chk("last_beat", 32'(last_xy), 32'({8'd159, 7'd119}));
        end
    endtask

    initial begin
        int clr_cyc;
        int bad_valid;
        bit seen;

        vecs[0] = '{8'd0,   7'd0,   3'd5, 1'b1};
        vecs[1] = '{8'd159, 7'd119, 3'd2, 1'b1};
        vecs[2] = '{8'd37,  7'd64,  3'd7, 1'b1};
        vecs[3] = '{8'd160, 7'd0,   3'd7, 1'b0};
        vecs[4] = '{8'd0,   7'd120, 3'd7, 1'b0};
        vecs[5] = '{8'd255, 7'd127, 3'd7, 1'b0};
        vecs[6] = '{8'd2,   7'd0,   3'd4, 1'b1};
        vecs[7] = '{8'd2,   7'd0,   3'd6, 1'b1};
        vecs[8] = '{8'd11,  7'd0,   3'd3, 1'b1};

        rst_n       = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;
        vga_plot    = 1'b0;
        clear_start = 1'b0;
        scan_start  = 1'b0;
        scan_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_scan_valid", 32'(scan_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_scan_x", 32'(scan_x), 32'd0);
        chk("reset_scan_y", 32'(scan_y), 32'd0);
        chk("reset_scan_colour", 32'(scan_colour), 32'd0);
        rst_n = 1'b1;

        // Clear and scan requested together: clear must win.
        @(negedge clk);
        clear_start = 1'b1;
        scan_start  = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        scan_start  = 1'b0;
        chk("clear_wins_busy", 32'(busy), 32'd1);
        chk("clear_wins_valid", 32'(scan_valid), 32'd0);
        for (int i = 0; i < 19200; i++) model[i] = 3'd0;

        clr_cyc   = 0;
        bad_valid = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i > 0) @(negedge clk);
            if (!busy) break;
            clr_cyc++;
            if (scan_valid) bad_valid++;
            if (i == 100) scan_start = 1'b1;
            if (i == 101) scan_start = 1'b0;
            if (i == 200) begin
                vga_x      = 8'd5;
                vga_y      = 7'd5;
                vga_colour = 3'd7;
                vga_plot   = 1'b1;
            end
            if (i == 201) vga_plot = 1'b0;
        end
        chk("clear_cycles", 32'(clr_cyc), 32'd19200);
        chk("valid_during_clear", 32'(bad_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_after_clear", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            plot(vecs[i].x, vecs[i].y, vecs[i].c);
            chk("plot_idle_busy", 32'(busy), 32'd0);
            if (vecs[i].acc) model[int'(vecs[i].y) * 160 + int'(vecs[i].x)] = vecs[i].c;
        end

        run_scan(1'b1, 1'b0);

        repeat (2) @(negedge clk);
        run_scan(1'b0, 1'b1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        scan_ready = 1'b1;
        repeat (2) @(negedge clk);

        load_expected();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (scan_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("restart_valid", 32'(seen), 32'd1);
        chk("restart_beat", 32'({scan_x, scan_y, scan_colour}), 32'(sb_q[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
